ahb_mem_responder: RTL
======================

# ahb_mem_responder

AHB-Lite subordinate with an internal word-organised memory, serving line-fill reads issued by the cache's AHB manager port. It sits on the bus between the cache and the system memory map and provides configurable wait states, ERROR responses for illegal accesses, and optional write support. It is used as the standard memory model in cache benches and as the on-chip boot memory.

## Interface
- ADDR_WIDTH, 32, HADDR width
- WORD_WIDTH, 32, data bus width; only 32 is supported
- MEM_DEPTH_WORDS, 1024, number of memory words
- LOG2_MEM_DEPTH, 10, word-index width; must equal log2(MEM_DEPTH_WORDS)
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
- WAIT_STATES, 0, wait cycles inserted into every OKAY data phase; range 0..15
- HBURST_WIDTH, 1, HBURST width
- HCLK  input  1  bus clock; all state changes on rising edge
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  1  subordinate select
- HADDR  input  ADDR_WIDTH  transfer byte address
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  input  1  1 = write
- HSIZE  input  3  transfer size; only 3'b010 (word) is legal
- HBURST  input  HBURST_WIDTH  ignored; every beat carries its own address
- HWDATA  input  WORD_WIDTH  write data, sampled in the data phase
- HWSTRB  input  WORD_WIDTH/8  byte-lane write enables
- HREADY  input  1  bus-level ready; an address phase is taken only when this is 1
- HREADYOUT  output  1  this subordinate's ready
- HRESP  output  1  0 = OKAY, 1 = ERROR
- HRDATA  output  WORD_WIDTH  read data

## Operation
- Accept: at a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1, the block captures HADDR, HWRITE and HSIZE. NONSEQ and SEQ are handled identically.
- IDLE or BUSY transfers, or HSEL=0: no access; OKAY response with zero wait.
- Index = (HADDR − BASE_ADDR) >> 2, truncated to LOG2_MEM_DEPTH bits.
- Illegal access, any of:
  - HADDR < BASE_ADDR
  - index ≥ MEM_DEPTH_WORDS (compare on the full-width difference)
  - HADDR[1:0] ≠ 0
  - HSIZE ≠ 3'b010
  - write with AHB_MEM_WRITE_EN undefined
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: wait counter > 0.
  - DATA: final OKAY cycle.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions from an accepted transfer:
  - Legal, WAIT_STATES>0 → WAIT, with the counter loaded to WAIT_STATES; each cycle it decrements, and at 1 the FSM moves to DATA.
  - Legal, WAIT_STATES=0 → DATA.
  - Illegal → ERR1 → ERR2.
- From DATA or ERR2: a new accept goes straight to its next state; otherwise → IDLE.
- Reads: the memory is read when the data phase completes and HRDATA is registered, so it is valid in the cycle where HREADYOUT=1 and HRESP=0. HRDATA holds its last value otherwise.
- Writes: at the edge ending DATA, each byte lane with HWSTRB[i]=1 is updated from HWDATA.
- Read-after-write: if a read address phase overlaps a write's final data cycle to the same index, the read returns the merged new data (bypass).
- No accesses are issued during ERR1/ERR2 except the one accepted in ERR2.
- The array is named `mem`, is not reset, and is preloadable by hierarchical backdoor.

## Timing
- Reset (HRESETn=0, asynchronous): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, counter=0. A pending write is discarded.
- Read latency: address phase at edge N; HRDATA valid, with HREADYOUT=1, in the cycle after edge N+WAIT_STATES+1.
- Pipelined back-to-back transfers with WAIT_STATES=0 sustain one beat per cycle, e.g. an 8-beat line fill completes in 9 cycles from the first address phase.
- While HREADYOUT=0, the manager holds the next address phase; the block re-evaluates it only when the bus HREADY is 1.
- ERROR response is always exactly two cycles, independent of WAIT_STATES.
- Simultaneous reset and transfer: reset wins.

## Configuration
- AHB_MEM_WRITE_EN:
  - Defined: writes are supported as above.
  - Undefined: the block is read-only. Any write transfer gets a two-cycle ERROR, memory is unchanged, and the write datapath and bypass are not synthesised.

## Test plan
- Reset, WAIT_STATES=0, mem[i]=32'hA000_0000+i; 8 sequential reads from 0x00 to 0x1C → HRDATA A0000000..A0000007 on consecutive cycles, HRESP=0, HREADYOUT never low.
- WAIT_STATES=3, single read at 0x40 → HREADYOUT low for 3 cycles, then high with HRDATA=A0000010.
- Read at BASE_ADDR+4*MEM_DEPTH_WORDS → cycle 1: HREADYOUT=0, HRESP=1; cycle 2: HREADYOUT=1, HRESP=1; HRDATA unchanged.
- HSIZE=3'b000 at 0x04, and HADDR=0x06 with HSIZE=3'b010 → each gets a two-cycle ERROR.
- With AHB_MEM_WRITE_EN, write 0x1122_3344 to 0x08 with HWSTRB=4'b0101, immediately followed by a read of 0x08 → HRDATA=0xA022_0044 via bypass. Without the macro, the same write → ERROR and the following read returns 0xA000_0002.
- HRESETn pulsed low during the WAIT state of a read → HREADYOUT=1, HRESP=0 and HRDATA=0 immediately; the next read at 0x00 completes normally.

Source files
------------

// File: rtl/ahb_mem_responder_if.sv
// AHB-Lite signal bundle between a manager and the ahb_mem_responder subordinate.
interface ahb_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned HBURST_WIDTH = 1
);
    logic                      HSEL;
    logic [ADDR_WIDTH-1:0]     HADDR;
    logic [1:0]                HTRANS;
    logic                      HWRITE;
    logic [2:0]                HSIZE;
    logic [HBURST_WIDTH-1:0]   HBURST;
    logic [WORD_WIDTH-1:0]     HWDATA;
    logic [WORD_WIDTH/8-1:0]   HWSTRB;
    logic                      HREADY;
    logic                      HREADYOUT;
    logic                      HRESP;
    logic [WORD_WIDTH-1:0]     HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB,
        input  HREADY, HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_mem_responder.sv
// AHB-Lite subordinate backed by a word memory, with fixed wait states and two-cycle ERROR replies.
// Write support (with read-after-write bypass) exists only when AHB_MEM_WRITE_EN is defined.
module ahb_mem_responder #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           WORD_WIDTH      = 32,
    parameter int unsigned           MEM_DEPTH_WORDS = 1024,
    parameter int unsigned           LOG2_MEM_DEPTH  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int unsigned           WAIT_STATES     = 0,
    parameter int unsigned           HBURST_WIDTH    = 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_mem_responder_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    localparam int unsigned           NB       = WORD_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(MEM_DEPTH_WORDS);
    localparam logic [3:0]            LP_WAIT  = 4'(WAIT_STATES);

    logic [WORD_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    state_t                    r_state, w_state_nxt;
    logic [3:0]                r_cnt, w_cnt_nxt;
    logic [LOG2_MEM_DEPTH-1:0] r_idx;
    logic [WORD_WIDTH-1:0]     r_rdata;

    logic [ADDR_WIDTH-1:0]     w_diff, w_off;
    logic [LOG2_MEM_DEPTH-1:0] w_idx, w_rd_idx;
    logic                      w_take, w_bad_addr, w_illegal, w_load;
    logic [WORD_WIDTH-1:0]     w_rd_word;
    logic                      w_unused;

    assign w_diff     = bus.HADDR - BASE_ADDR;
    assign w_off      = w_diff >> 2;
    assign w_idx      = w_off[LOG2_MEM_DEPTH-1:0];
    assign w_bad_addr = (bus.HADDR < BASE_ADDR) || (w_off >= LP_DEPTH) ||
                        (bus.HADDR[1:0] != 2'b00) || (bus.HSIZE != 3'b010);
    assign w_take     = bus.HSEL && bus.HREADY && bus.HTRANS[1] &&
                        (r_state inside {S_IDLE, S_DATA, S_ERR2});
    assign w_rd_idx   = w_take ? w_idx : r_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) w_state_nxt = S_DATA;
            end
            S_ERR1: w_state_nxt = S_ERR2;
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
                if (w_take) begin
                    if (w_illegal) begin
                        w_state_nxt = S_ERR1;
                    end else if (LP_WAIT != 4'd0) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = LP_WAIT;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) r_idx <= w_idx;
        end
    end

    // Read data is registered on entry to DATA so it is valid alongside HREADYOUT.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_rdata <= '0;
        else if (w_load) r_rdata <= w_rd_word;
    end

`ifdef AHB_MEM_WRITE_EN
    logic r_write;
    logic w_wr_commit;

    assign w_illegal   = w_bad_addr;
    assign w_wr_commit = (r_state == S_DATA) && r_write;
    assign w_load      = (w_state_nxt == S_DATA) && (w_take ? !bus.HWRITE : !r_write);
    assign w_unused    = ^{bus.HBURST, bus.HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_write <= 1'b0;
        else if (w_take) r_write <= bus.HWRITE;
    end

    always_ff @(posedge HCLK) begin
        if (w_wr_commit) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (bus.HWSTRB[b]) mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end

    // A read accepted on the edge that commits a write to the same word sees the merged lanes.
    always_comb begin
        w_rd_word = mem[w_rd_idx];
        if (w_wr_commit && (r_idx == w_rd_idx)) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (bus.HWSTRB[b]) w_rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
            end
        end
    end
`else
    assign w_illegal = w_bad_addr || bus.HWRITE;
    assign w_load    = (w_state_nxt == S_DATA);
    assign w_rd_word = mem[w_rd_idx];
    assign w_unused  = ^{bus.HBURST, bus.HTRANS[0], bus.HWDATA, bus.HWSTRB};
`endif

    assign bus.HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
    assign bus.HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign bus.HRDATA    = r_rdata;
endmodule
